// File: rtl/nco_iq_demod.sv
// nco_iq_demod: mixes a signed ADC stream with the NCO sine/cosine,
// integrates each product over DECIM valid samples (accumulate-and-dump),
// scales and saturates the sums, and presents one {Q,I} beat per frame.
module nco_iq_demod #(
    parameter int ADC_WIDTH        = 14,
    parameter int AMPLITUDE_BITS   = 14,
    parameter int DECIM_BITS       = 16,
    parameter int ACC_WIDTH        = 48,
    parameter int OUT_WIDTH        = 32,
    parameter int AXIS_TDATA_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADC_WIDTH-1:0]        S_AXIS_ADC_TDATA,
    input  logic                        S_AXIS_ADC_TVALID,
    input  logic [AMPLITUDE_BITS-1:0]   SINE_WAVE,
    input  logic [AMPLITUDE_BITS-1:0]   COS_WAVE,
    input  logic [DECIM_BITS-1:0]       DECIM,
    input  logic [5:0]                  SHIFT,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_IQ_TDATA,
    output logic                        M_AXIS_IQ_TVALID,
    input  logic                        M_AXIS_IQ_TREADY,
    output logic                        OVERFLOW,
    output logic                        SATURATED
);

    localparam int PROD_W = ADC_WIDTH + AMPLITUDE_BITS;

    // Largest and smallest values representable in an OUT_WIDTH signed word,
    // expressed at accumulator width for the clamp comparison.
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    if (ACC_WIDTH < ADC_WIDTH + AMPLITUDE_BITS + DECIM_BITS) begin : g_acc_width_check
        $error("ACC_WIDTH cannot hold a full frame of products without wrapping");
    end
    if (ACC_WIDTH <= OUT_WIDTH) begin : g_out_width_check
        $error("ACC_WIDTH must be wider than OUT_WIDTH");
    end
    if (AXIS_TDATA_WIDTH != 2 * OUT_WIDTH) begin : g_tdata_width_check
        $error("AXIS_TDATA_WIDTH must equal 2*OUT_WIDTH");
    end

    logic signed [ADC_WIDTH-1:0]      adc_r;
    logic signed [AMPLITUDE_BITS-1:0] sin_r;
    logic signed [AMPLITUDE_BITS-1:0] cos_r;
    logic                             vld0;

    logic signed [PROD_W-1:0]         prod_i;
    logic signed [PROD_W-1:0]         prod_q;
    logic                             vld1;

    logic signed [ACC_WIDTH-1:0]      acc_i;
    logic signed [ACC_WIDTH-1:0]      acc_q;
    logic signed [ACC_WIDTH-1:0]      dump_i;
    logic signed [ACC_WIDTH-1:0]      dump_q;
    logic                             dump_vld;
    logic [DECIM_BITS-1:0]            cnt;
    logic [DECIM_BITS-1:0]            len_r;

    logic [DECIM_BITS-1:0]            decim_eff;
    logic [DECIM_BITS-1:0]            frame_len;
    logic                             last;
    logic signed [ACC_WIDTH-1:0]      sum_i;
    logic signed [ACC_WIDTH-1:0]      sum_q;

    logic signed [ACC_WIDTH-1:0]      sh_i;
    logic signed [ACC_WIDTH-1:0]      sh_q;
    logic [OUT_WIDTH-1:0]             res_i;
    logic [OUT_WIDTH-1:0]             res_q;
    logic                             clip_i;
    logic                             clip_q;

    // E0: capture ADC sample, NCO phase pair and valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adc_r <= '0;
            sin_r <= '0;
            cos_r <= '0;
            vld0  <= 1'b0;
        end else begin
            adc_r <= $signed(S_AXIS_ADC_TDATA);
            sin_r <= $signed(SINE_WAVE);
            cos_r <= $signed(COS_WAVE);
            vld0  <= S_AXIS_ADC_TVALID;
        end
    end

    // E1: full-precision signed mixer products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_i <= '0;
            prod_q <= '0;
            vld1   <= 1'b0;
        end else begin
            prod_i <= PROD_W'(adc_r) * PROD_W'(cos_r);
            prod_q <= PROD_W'(adc_r) * PROD_W'(sin_r);
            vld1   <= vld0;
        end
    end

    // Frame length is taken from DECIM only at the first product of a frame,
    // so a DECIM change mid-frame waits for the next frame.
    always_comb begin
        decim_eff = (DECIM == '0) ? DECIM_BITS'(1) : DECIM;
        frame_len = (cnt == '0) ? decim_eff : len_r;
        last      = ({1'b0, cnt} + 1'b1) == {1'b0, frame_len};
        sum_i     = acc_i + ACC_WIDTH'(prod_i);
        sum_q     = acc_q + ACC_WIDTH'(prod_q);
    end

    // E2: accumulate valid products; on the frame's last product dump the sum and restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_i    <= '0;
            acc_q    <= '0;
            dump_i   <= '0;
            dump_q   <= '0;
            dump_vld <= 1'b0;
            cnt      <= '0;
            len_r    <= '0;
        end else begin
            dump_vld <= 1'b0;
            if (vld1) begin
                if (cnt == '0) begin
                    len_r <= decim_eff;
                end
                if (last) begin
                    cnt      <= '0;
                    acc_i    <= '0;
                    acc_q    <= '0;
                    dump_i   <= sum_i;
                    dump_q   <= sum_q;
                    dump_vld <= 1'b1;
                end else begin
                    cnt   <= cnt + 1'b1;
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                end
            end
        end
    end

    // Sign-preserving scale followed by clamp to the output word range.
    always_comb begin
        sh_i   = dump_i >>> SHIFT;
        sh_q   = dump_q >>> SHIFT;
        res_i  = sh_i[OUT_WIDTH-1:0];
        res_q  = sh_q[OUT_WIDTH-1:0];
        clip_i = 1'b0;
        clip_q = 1'b0;
        if (sh_i > OUT_MAX) begin
            res_i  = OUT_MAX[OUT_WIDTH-1:0];
            clip_i = 1'b1;
        end else if (sh_i < OUT_MIN) begin
            res_i  = OUT_MIN[OUT_WIDTH-1:0];
            clip_i = 1'b1;
        end
        if (sh_q > OUT_MAX) begin
            res_q  = OUT_MAX[OUT_WIDTH-1:0];
            clip_q = 1'b1;
        end else if (sh_q < OUT_MIN) begin
            res_q  = OUT_MIN[OUT_WIDTH-1:0];
            clip_q = 1'b1;
        end
    end

    // E3: single-beat output register; a result arriving while the old beat is stalled is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            M_AXIS_IQ_TDATA  <= '0;
            M_AXIS_IQ_TVALID <= 1'b0;
            OVERFLOW         <= 1'b0;
            SATURATED        <= 1'b0;
        end else begin
            if (dump_vld) begin
                if (clip_i || clip_q) begin
                    SATURATED <= 1'b1;
                end
                if (!M_AXIS_IQ_TVALID || M_AXIS_IQ_TREADY) begin
                    M_AXIS_IQ_TDATA  <= {res_q, res_i};
                    M_AXIS_IQ_TVALID <= 1'b1;
                end else begin
                    OVERFLOW <= 1'b1;
                end
            end else if (M_AXIS_IQ_TVALID && M_AXIS_IQ_TREADY) begin
                M_AXIS_IQ_TVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nco_iq_demod.sv
// Self-checking bench for nco_iq_demod: fixed vector table, hand-written
// corner sequences, and randomized traffic against a frame-level model.
module tb_nco_iq_demod;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic [13:0] sine = '0;
    logic [13:0] cosw = '0;
    logic [15:0] decim = 16'd1;
    logic [5:0]  shift = '0;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        overflow;
    logic        saturated;

    nco_iq_demod dut (
        .clk               (clk),
        .rst               (rst),
        .S_AXIS_ADC_TDATA  (s_tdata),
        .S_AXIS_ADC_TVALID (s_tvalid),
        .SINE_WAVE         (sine),
        .COS_WAVE          (cosw),
        .DECIM             (decim),
        .SHIFT             (shift),
        .M_AXIS_IQ_TDATA   (m_tdata),
        .M_AXIS_IQ_TVALID  (m_tvalid),
        .M_AXIS_IQ_TREADY  (m_tready),
        .OVERFLOW          (overflow),
        .SATURATED         (saturated)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        bit          sat;
    } exp_t;

    typedef struct {
        int                 dec;
        int                 sh;
        int                 adc;
        int                 sn;
        int                 cs;
        logic signed [31:0] ei;
        logic signed [31:0] eq;
        bit                 esat;
    } vec_t;

    int     n_chk = 0;
    int     n_fail = 0;
    int     hs_count = 0;
    bit     mon_en = 1'b0;
    exp_t   exp_q[$];
    int     m_cnt = 0;
    int     m_len = 1;
    longint m_si = 0;
    longint m_sq = 0;
    bit     m_sat_any = 1'b0;
    vec_t   tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference scaling: floor-divide by 2^sh, then clamp to 32-bit signed.
    function automatic void scale(input longint sum, input int sh,
                                  output logic [31:0] r, output bit clip);
        longint v;
        v = sum >>> sh;
        clip = 1'b0;
        if (v > 64'sd2147483647) begin
            r = 32'h7FFFFFFF;
            clip = 1'b1;
        end else if (v < -64'sd2147483648) begin
            r = 32'h80000000;
            clip = 1'b1;
        end else begin
            r = v[31:0];
        end
    endfunction

    task automatic model_clear();
        m_cnt = 0;
        m_si = 0;
        m_sq = 0;
        m_sat_any = 1'b0;
        exp_q.delete();
    endtask

    // Present one input cycle; valid samples are folded into the frame model.
    task automatic drive(input bit v, input int a, input int s, input int c);
        logic [31:0] ri, rq;
        bit ci, cq;
        s_tvalid = v;
        s_tdata = a[13:0];
        sine = s[13:0];
        cosw = c[13:0];
        if (v) begin
            if (m_cnt == 0) m_len = (decim == 0) ? 1 : int'(decim);
            m_si += longint'(a) * longint'(c);
            m_sq += longint'(a) * longint'(s);
            m_cnt++;
            if (m_cnt == m_len) begin
                scale(m_si, int'(shift), ri, ci);
                scale(m_sq, int'(shift), rq, cq);
                exp_q.push_back('{data: {rq, ri}, sat: ci | cq});
                m_sat_any |= ci | cq;
                m_cnt = 0;
                m_si = 0;
                m_sq = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_rst();
        s_tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic drain(input string name);
        s_tvalid = 1'b0;
        for (int w = 0; w < 20 && exp_q.size() != 0; w++) begin
            @(posedge clk);
            #1;
        end
        idle(3);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Every transferred beat is counted; when enabled it is matched against the model.
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            hs_count++;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", m_tdata, 64'hX);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("beat_tdata", m_tdata, e.data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int guard;

        tbl[0] = '{4,  0,   100,     0,  8191, 32'sd3276400,    32'sd0,         1'b0};
        tbl[1] = '{1,  0, -8192, -8192,  8191, -32'sd67100672,  32'sd67108864,  1'b0};
        tbl[2] = '{0,  0,     5,    -7,     3, 32'sd15,         -32'sd35,       1'b0};
        tbl[3] = '{64, 0,  8191,     0,  8191, 32'sh7FFFFFFF,   32'sd0,         1'b1};
        tbl[4] = '{64, 0, -8192,  8191,  8191, 32'sh80000000,   32'sh80000000,  1'b1};
        tbl[5] = '{64, 2,  8191,     0,  8191, 32'sd1073479696, 32'sd0,         1'b0};
        tbl[6] = '{3,  4,  -100,     0,    17, -32'sd319,       32'sd0,         1'b0};
        tbl[7] = '{10, 63, 1000, -1000,  1000, 32'sd0,          -32'sd1,        1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tdata", m_tdata, 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_saturated", 64'(saturated), 64'd0);

        // Constant-input frames from the vector table
        m_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            int n;
            pulse_rst();
            mon_en = 1'b0;
            decim = tbl[k].dec[15:0];
            shift = tbl[k].sh[5:0];
            n = (tbl[k].dec == 0) ? 1 : tbl[k].dec;
            for (int j = 0; j < n; j++) drive(1'b1, tbl[k].adc, tbl[k].sn, tbl[k].cs);
            s_tvalid = 1'b0;
            for (int w = 0; w < 10 && !m_tvalid; w++) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("tbl%0d_tvalid", k), 64'(m_tvalid), 64'd1);
            check($sformatf("tbl%0d_tdata", k), m_tdata, {tbl[k].eq, tbl[k].ei});
            check($sformatf("tbl%0d_saturated", k), 64'(saturated), 64'(tbl[k].esat));
        end

        // Latency: beat appears after the third edge following the last sample's capture
        pulse_rst();
        mon_en = 1'b0;
        decim = 16'd4;
        shift = '0;
        for (int j = 0; j < 4; j++) drive(1'b1, 100, 0, 8191);
        idle(2);
        check("lat_before_e3", 64'(m_tvalid), 64'd0);
        idle(1);
        check("lat_at_e3", 64'(m_tvalid), 64'd1);
        check("lat_tdata", m_tdata, {32'd0, 32'd3276400});

        // Valid toggling: invalid cycles carry junk that must not be summed
        pulse_rst();
        mon_en = 1'b1;
        decim = 16'd2;
        hs0 = hs_count;
        for (int i = 0; i < 16; i++) drive(i % 2 == 0, (i * 37 + 5) % 8000 - 4000, -i * 11, 500 - i * 90);
        drain("toggle_drain");
        check("toggle_beats", 64'(hs_count - hs0), 64'd4);

        // DECIM change while a 4-sample frame is already accumulating
        pulse_rst();
        decim = 16'd4;
        hs0 = hs_count;
        for (int i = 0; i < 3; i++) drive(1'b1, 1000 + i, 7 * i, 300 - i);
        decim = 16'd2;
        for (int i = 3; i < 8; i++) drive(1'b1, 1000 + i, 7 * i, 300 - i);
        drain("decim_change_drain");
        check("decim_change_beats", 64'(hs_count - hs0), 64'd3);

        // Backpressure: first beat held, later results dropped, then one transfer
        pulse_rst();
        mon_en = 1'b0;
        decim = 16'd1;
        m_tready = 1'b0;
        for (int i = 0; i < 10; i++) drive(1'b1, i + 1, 2, 1);
        idle(5);
        check("bp_tvalid", 64'(m_tvalid), 64'd1);
        check("bp_held", m_tdata, {32'd2, 32'd1});
        check("bp_overflow", 64'(overflow), 64'd1);
        hs0 = hs_count;
        m_tready = 1'b1;
        idle(5);
        check("bp_one_beat", 64'(hs_count - hs0), 64'd1);
        check("bp_tvalid_low", 64'(m_tvalid), 64'd0);
        check("bp_tdata_hold", m_tdata, {32'd2, 32'd1});
        exp_q.delete();
        mon_en = 1'b1;
        hs0 = hs_count;
        for (int i = 0; i < 3; i++) drive(1'b1, 20 + i, -3, 5);
        drain("bp_resume_drain");
        check("bp_resume_beats", 64'(hs_count - hs0), 64'd3);
        check("bp_overflow_sticky", 64'(overflow), 64'd1);

        // Reset mid-frame with both sticky flags set
        pulse_rst();
        mon_en = 1'b0;
        m_tready = 1'b0;
        decim = 16'd40;
        for (int j = 0; j < 80; j++) drive(1'b1, 8191, 0, 8191);
        idle(5);
        check("mr_pre_saturated", 64'(saturated), 64'd1);
        check("mr_pre_overflow", 64'(overflow), 64'd1);
        m_tready = 1'b1;
        decim = 16'd4;
        idle(3);
        exp_q.delete();
        m_cnt = 0;
        m_si = 0;
        m_sq = 0;
        drive(1'b1, 4000, 4000, 4000);
        drive(1'b1, 4000, 4000, 4000);
        s_tvalid = 1'b0;
        rst = 1'b1;
        #1;
        check("mr_tvalid", 64'(m_tvalid), 64'd0);
        check("mr_overflow", 64'(overflow), 64'd0);
        check("mr_saturated", 64'(saturated), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        mon_en = 1'b1;
        hs0 = hs_count;
        drive(1'b1, 11, 13, 17);
        drive(1'b1, -19, 23, -29);
        drive(1'b1, 31, -37, 41);
        drive(1'b1, 43, 47, -53);
        drain("mr_drain");
        check("mr_beats", 64'(hs_count - hs0), 64'd1);

        // Randomized traffic in blocks of fixed DECIM/SHIFT
        pulse_rst();
        mon_en = 1'b1;
        m_tready = 1'b1;
        for (int blk = 0; blk < 8; blk++) begin
            decim = (blk == 3 || blk == 6) ? 16'd64 : 16'($urandom_range(12));
            shift = 6'($urandom_range(24));
            for (int i = 0; i < 120; i++)
                drive($urandom_range(2) != 0, int'($urandom_range(16383)) - 8192,
                      int'($urandom_range(16383)) - 8192, int'($urandom_range(16383)) - 8192);
            guard = 0;
            while (m_cnt != 0 && guard < 400) begin
                drive(1'b1, int'($urandom_range(16383)) - 8192,
                      int'($urandom_range(16383)) - 8192, int'($urandom_range(16383)) - 8192);
                guard++;
            end
            drain($sformatf("rand_blk%0d_drain", blk));
        end
        check("rand_saturated", 64'(saturated), 64'(m_sat_any));
        check("rand_overflow", 64'(overflow), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
